// File: rtl/ram_load_sequencer.sv
// rtl/ram_load_sequencer.sv - streams DEPTH bytes into the memory demux, one location per accepted byte
module ram_load_sequencer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic [SEL_W:0]    count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [SEL_W:0] DEPTH_C   = (SEL_W+1)'(DEPTH);
  localparam logic [SEL_W:0] LAST_ADDR = (SEL_W+1)'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [SEL_W:0]      addr_q, addr_d;
  logic [SEL_W:0]      count_q, count_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic                accept;

  // Ready depends on registered state only, so it never combinationally follows in_valid.
  assign in_ready = (state_q == S_LOAD) && (addr_q < DEPTH_C);
  assign accept   = in_valid & in_ready;

  assign sel     = sel_q;
  assign wr_data = wr_data_q;
  assign wr_en   = wr_en_q;
  assign busy    = (state_q == S_LOAD);
  assign done    = (state_q == S_DONE);
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      sel_q     <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      sel_q     <= sel_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    sel_d     = sel_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          count_d = '0;
        end
      end

      S_LOAD: begin
        // Abort takes priority: a byte handshaken in the same cycle is dropped.
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept) begin
          sel_d     = addr_q[SEL_W-1:0];
          wr_data_d = in_data;
          wr_en_d   = 1'b1;
          addr_d    = addr_q + 1'b1;
          count_d   = count_q + 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          count_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_load_sequencer.sv
// tb/tb_ram_load_sequencer.sv - scoreboard bench for ram_load_sequencer
module tb_ram_load_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [3:0] sel;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       busy;
  logic       done;
  logic [4:0] count;

  ram_load_sequencer #(.DATA_W(8), .DEPTH(16), .SEL_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .sel      (sel),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          strobes  = 0;
  logic [11:0] exp_q[$];
  logic [11:0] e;
  logic [3:0]  last_sel;
  logic [7:0]  last_data;
  logic        prev_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Monitor: every strobe must match the oldest accepted byte; between strobes sel/wr_data hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_sel  = 4'h0;
      last_data = 8'h00;
      prev_wr   = 1'b0;
    end else if (wr_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: sel=%0d data=%0h, expected no strobe", sel, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("strobe_sel", 32'(sel), 32'(e[11:8]));
        check("strobe_data", 32'(wr_data), 32'(e[7:0]));
      end
      if (prev_wr) check("repeat_sel", 32'(sel == last_sel), 32'd0);
      last_sel  = sel;
      last_data = wr_data;
      prev_wr   = 1'b1;
      strobes++;
    end else begin
      check("hold_sel", 32'(sel), 32'(last_sel));
      check("hold_data", 32'(wr_data), 32'(last_data));
      prev_wr = 1'b0;
    end
  end

  task automatic send(input logic [7:0] d, input int k, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        exp_q.push_back({4'(k), d});
        @(posedge clk);
        #1;
        return;
      end
      waits++;
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_timeout: byte %0d in_ready=%0b, expected 1", k, in_ready);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_count", 32'(count), 32'd0);
    check("start_ready", 32'(in_ready), 32'd1);
    check("start_wr_en", 32'(wr_en), 32'd0);
  endtask

  task automatic run_load(input logic [7:0] base, input bit gaps);
    int w;
    int tot;
    tot = 0;
    start_pulse();
    for (int k = 0; k < 16; k++) begin
      send(8'(base + 8'(k)), k, w);
      tot += w;
      if (gaps) begin
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    if (!gaps) check("no_stall", 32'(tot), 32'd0);
    @(posedge clk);
    #1;
    check("end_done", 32'(done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_ready", 32'(in_ready), 32'd0);
    check("end_wr_en", 32'(wr_en), 32'd0);
    check("end_count", 32'(count), 32'd16);
    check("end_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int w;
    // 1: reset and idle with a pending source
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (5) begin
      @(negedge clk);
      check("idle_ready", 32'(in_ready), 32'd0);
      check("idle_wr_en", 32'(wr_en), 32'd0);
      check("idle_sel", 32'(sel), 32'd0);
      check("idle_count", 32'(count), 32'd0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // 2: continuous full load, then abort in DONE is ignored
    run_load(8'h10, 1'b0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_in_done_done", 32'(done), 32'd1);
    check("abort_in_done_count", 32'(count), 32'd16);

    // 3: bursty source 1,0,0
    run_load(8'hA0, 1'b1);

    // 4: abort on the sixth byte
    start_pulse();
    for (int k = 0; k < 5; k++) send(8'(8'h30 + 8'(k)), k, w);
    in_data = 8'h35;
    abort   = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_wr_en", 32'(wr_en), 32'd0);
    check("abort_count", 32'(count), 32'd5);
    check("abort_sel", 32'(sel), 32'd4);
    check("abort_data", 32'(wr_data), 32'h34);
    @(posedge clk);
    #1;
    check("abort_after_wr_en", 32'(wr_en), 32'd0);
    check("abort_after_count", 32'(count), 32'd5);

    // 5: reset after nine bytes
    start_pulse();
    for (int k = 0; k < 9; k++) send(8'(8'h70 + 8'(k)), k, w);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sel", 32'(sel), 32'd0);
    check("arst_data", 32'(wr_data), 32'd0);
    check("arst_wr_en", 32'(wr_en), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_queue", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("post_rst_wr_en", 32'(wr_en), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    run_load(8'h50, 1'b0);

    // 6: restart straight from DONE
    run_load(8'h10, 1'b0);

    @(posedge clk);
    #1;
    check("final_queue", 32'(exp_q.size()), 32'd0);
    check("total_strobes", 32'(strobes), 32'd78);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
